// File: rtl/nios_128k_base_pkg.sv
// Shared constants for the nios_128k_base platform peripherals.
// No logic of its own; register addresses and default debounce length.
// Not applicable (no datapath or flow control here).
package nios_128k_base_pkg;

  // Button controller register map (word addresses)
  localparam logic [1:0] BTN_REG_DATA = 2'd0;
  localparam logic [1:0] BTN_REG_RAW  = 2'd1;
  localparam logic [1:0] BTN_REG_MASK = 2'd2;
  localparam logic [1:0] BTN_REG_EDGE = 2'd3;

  // 1 ms of stability at a 50 MHz system clock
  localparam int BTN_DEBOUNCE_CYCLES = 50000;

  // Write-one-to-clear with a same-cycle set taking priority over the clear
  function automatic logic [31:0] btn_w1c(input logic [31:0] cur,
                                          input logic [31:0] clr,
                                          input logic [31:0] set);
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/nios_128k_base_button_debounce.sv
// One button line: 2-flop synchronizer, stability counter, accepted level, press pulse.
// Latency: 2 cycles to sync, then DEBOUNCE_CYCLES cycles of steady mismatch to accept.
// No backpressure; fall is a one-cycle pulse coincident with the accepting edge.
module nios_128k_base_button_debounce
  import nios_128k_base_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic sync,
  output logic stable,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Final count reached while still disagreeing: the new level is taken on this edge
  assign accept = (sync != stable) && (cnt == CNT_LAST);
  // Press is a released (1) level being replaced by a pressed (0) one
  assign fall   = accept && stable;

  // Two-flop synchronizer; resets to released so no edge appears out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (sync == stable) begin
      cnt    <= '0;
    end else if (accept) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios_128k_base_button_ctrl.sv
// Avalon-MM push-button controller: debounced/raw levels, IRQ mask, sticky press capture.
// Read data registered (1 cycle); writes take effect at the next edge; irq same cycle as capture.
// Zero wait states, never stalls the bus; button lines are sampled every cycle.
module nios_128k_base_button_ctrl
  import nios_128k_base_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] raw_lvl;
  logic [WIDTH-1:0] deb_lvl;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      edge_nxt;
  logic [31:0]      rd_nxt;
  logic             wr_en;

  // Per-line conditioning
  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    nios_128k_base_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .btn_in (in_port[i]),
      .sync   (raw_lvl[i]),
      .stable (deb_lvl[i]),
      .fall   (press[i])
    );
  end

  // Upper write-data bits have no storage behind them
  if (WIDTH < 32) begin : g_wd_hi
    logic wdata_hi_unused;
    assign wdata_hi_unused = ^writedata[31:WIDTH];
  end

  assign wr_en    = chipselect && !write_n;
  assign edge_clr = (wr_en && (address == BTN_REG_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign edge_nxt = btn_w1c(32'(edge_cap), 32'(edge_clr), 32'(press));

  // Interrupt comes straight from the mask and capture registers
  assign irq = |(edge_cap & irq_mask);

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && (address == BTN_REG_MASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky press capture; a press on the clearing cycle survives the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= edge_nxt[WIDTH-1:0];
    end
  end

  // Read mux, evaluated every cycle regardless of chipselect
  always_comb begin
    rd_nxt = '0;
    case (address)
      BTN_REG_DATA: rd_nxt[WIDTH-1:0] = deb_lvl;
      BTN_REG_RAW:  rd_nxt[WIDTH-1:0] = raw_lvl;
      BTN_REG_MASK: rd_nxt[WIDTH-1:0] = irq_mask;
      default:      rd_nxt[WIDTH-1:0] = edge_cap;
    endcase
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_nios_128k_base_button_ctrl.sv
// Self-checking bench for nios_128k_base_button_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4.
// Directed scenarios with literal expectations, then randomized buttons and bus traffic.
// Outputs are compared against a window-based reference model on every falling edge.
module tb_nios_128k_base_button_ctrl;

  localparam int W = 4;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios_128k_base_button_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Synced level = in_port delayed by two edges; a debounced bit takes the synced
  // level once the last N synced samples all disagree with the current debounced level.
  logic [W-1:0] pipe[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_mask, m_edge;
  logic [31:0]  m_rd;
  bit           m_valid = 0;

  always @(posedge clk) begin
    logic [W-1:0] pre_sync, fall, clr, nxt;
    bit           all_diff;
    if (reset) begin
      pipe.delete();
      pipe.push_back({W{1'b1}});
      pipe.push_back({W{1'b1}});
      hist.delete();
      m_stable = {W{1'b1}};
      m_mask   = '0;
      m_edge   = '0;
      m_rd     = '0;
      m_valid  = 1;
    end else if (m_valid) begin
      pre_sync = pipe.pop_front();
      pipe.push_back(in_port);
      hist.push_back(pre_sync);
      if (hist.size() > N) void'(hist.pop_front());

      case (address)
        2'd0:    m_rd = 32'(m_stable);
        2'd1:    m_rd = 32'(pre_sync);
        2'd2:    m_rd = 32'(m_mask);
        default: m_rd = 32'(m_edge);
      endcase

      fall = '0;
      nxt  = m_stable;
      if (hist.size() == N) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1;
          foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 0;
          if (all_diff) begin
            nxt[i] = ~m_stable[i];
            if (m_stable[i]) fall[i] = 1'b1;
          end
        end
      end

      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_edge   = (m_edge & ~clr) | fall;
      m_stable = nxt;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_readdata", readdata, m_rd);
      chk("model_irq", 32'(irq), 32'(|(m_edge & m_mask)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int hold;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = '1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    tick();
    chk("rst_data", readdata, 32'hF);
    address = 2'd2;
    tick();
    chk("rst_mask", readdata, 32'h0);
    address = 2'd3;
    tick();
    chk("rst_edge", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Clean press of bit 0: debounced level flips on the 6th edge, seen on readdata one edge later
    address = 2'd0;
    in_port = 4'b1110;
    repeat (6) tick();
    chk("press_data_early", readdata, 32'hF);
    tick();
    chk("press_data", readdata, 32'hE);
    address = 2'd3;
    tick();
    chk("press_edge", readdata, 32'h1);
    chk("press_irq_masked", 32'(irq), 32'h0);

    // Release, clear, then a 3-cycle glitch on bit 1 must be rejected
    in_port = '1;
    repeat (8) tick();
    bus_write(2'd3, 32'hF);
    in_port = 4'b1101;
    repeat (3) tick();
    in_port = '1;
    repeat (10) tick();
    address = 2'd0;
    tick();
    chk("glitch_data", readdata, 32'hF);
    address = 2'd3;
    tick();
    chk("glitch_edge", readdata, 32'h0);

    // Interrupt path
    bus_write(2'd2, 32'h1);
    in_port = 4'b1110;
    repeat (8) tick();
    chk("irq_set", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h1);
    chk("irq_clr", 32'(irq), 32'h0);
    address = 2'd0;
    tick();
    chk("irq_data_held", readdata, 32'hE);

    // Clear of bit 2 on the very edge its press is accepted: set wins
    in_port = 4'b1010;
    repeat (5) tick();
    bus_write(2'd3, 32'h4);
    address = 2'd3;
    tick();
    chk("collide_edge", readdata, 32'h4);
    chk("collide_irq", 32'(irq), 32'h0);

    // Reset in the middle of debouncing bit 3 discards the partial count
    in_port = '1;
    repeat (8) tick();
    bus_write(2'd3, 32'hF);
    in_port = 4'b0111;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset   = 1'b0;
    address = 2'd0;
    tick();
    chk("rmd_data_after", readdata, 32'hF);
    repeat (5) tick();
    chk("rmd_data_not_yet", readdata, 32'hF);
    tick();
    chk("rmd_data", readdata, 32'h7);
    address = 2'd3;
    tick();
    chk("rmd_edge", readdata, 32'h8);

    // Randomized buttons, bus traffic and occasional resets
    repeat (300) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      in_port = W'($urandom);
      hold    = $urandom_range(1, 2 * N + 3);
      repeat (hold) begin
        chipselect = ($urandom_range(0, 3) == 0);
        write_n    = ($urandom_range(0, 1) == 1);
        address    = 2'($urandom);
        writedata  = $urandom;
        tick();
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios_128k_base_button_ctrl.md
# nios_128k_base_button_ctrl

Avalon-MM slave controller for the board push-buttons on the `nios_128k_base` platform. It synchronizes and debounces each raw button line and captures press (falling) edges into a sticky register. It raises a maskable interrupt to the Nios II and exposes debounced state, raw state, mask and edge-capture registers to software. It replaces the plain read-only button PIO in the Qsys system.

## Interface
Parameters:
- `WIDTH`, 4: number of button lines.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a new level (1 ms at 50 MHz); legal range 2..2^20.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: debounce counter width (derived, not overridden).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  word address of the register.
- `chipselect`  in  1  slave selected.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  raw, asynchronous, active-low button lines (released = 1).
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt request.

## Operation
- Register map (word addresses):
  - 0 DATA (RO): debounced levels, bits [WIDTH-1:0].
  - 1 RAW (RO): synchronized, undebounced levels.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAP (RW1C): sticky press flags; writing 1 clears the bit, writing 0 has no effect.
- Unused upper bits read as 0. Writes to 0 and 1 are ignored.
- Write occurs when `chipselect && !write_n`, with zero wait states.
- Per bit:
  - Two-flop synchronizer → `sync`.
  - Counter `cnt` and accepted level `stable`.
    - If `sync == stable`: `cnt <= 0`.
    - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync`, `cnt <= 0`.
    - Else: `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and `stable` is unchanged.
- Edge detect: press = `stable` transitions 1→0. This sets `EDGECAP[i]`. Release edges are not captured.
- Simultaneous press event and W1C clear on the same bit: set wins.
- `irq = |(EDGECAP & IRQMASK)`, driven from registers with no combinational path from bus inputs.
- `readdata` is updated every cycle from `address` (mux of the four registers), independent of `chipselect`.

## Timing
- Reset values:
  - `readdata = 0`, `irq = 0`, `IRQMASK = 0`, `EDGECAP = 0`, `cnt = 0`.
  - Synchronizer flops and `stable` reset to all-ones (released), so reset produces no spurious edge.
- Read latency is 1 cycle: `readdata` reflects the registers as of the edge at which `address` is sampled.
- `in_port` change to `sync` change: 2 cycles.
- `sync` change to `stable` change: DEBOUNCE_CYCLES cycles of uninterrupted mismatch.
- `stable` falling to `EDGECAP` set: same edge as `stable` updates (+1 cycle).
- `EDGECAP` set to `irq` high: combinational from the `EDGECAP` register, so high in the same cycle.
- A write to IRQMASK or EDGECAP takes effect at the next edge; `irq` follows in that cycle.
- Reset asserted mid-debounce: the counter is discarded; after reset, the input must again be stable for the full DEBOUNCE_CYCLES.
- A held button produces exactly one EDGECAP set. A press/release/press sequence produces a new set only after each debounced release.

## Structure
- Shared package `nios_128k_base_pkg`:
  - Register address constants `BTN_REG_DATA`/`RAW`/`MASK`/`EDGE` (0..3).
  - Default `DEBOUNCE_CYCLES`.
- Sub-module `nios_128k_base_button_debounce`: one bit's synchronizer, counter and `stable` register, plus a `fall` pulse output. It is instantiated WIDTH times via generate. The top holds the bus registers, edge capture, irq and read mux.

## Test plan
Run with `DEBOUNCE_CYCLES=4`, `WIDTH=4`.
- Reset check: after reset, read addr 0 → 0xF, addr 2 → 0x0, addr 3 → 0x0; `irq=0`.
- Clean press:
  - Drive `in_port=4'b1110` and hold.
  - DATA reads 0xE exactly 2+4 cycles later, and EDGECAP=0x1.
  - `irq` stays 0 because the mask is 0.
- Glitch rejection: pulse bit 1 low for 3 cycles → DATA stays 0xF and EDGECAP stays 0.
- Interrupt path:
  - Write IRQMASK=0x1, then press bit 0 → `irq=1`.
  - Write EDGECAP=0x1 → `irq=0` on the next cycle; DATA still 0xE while held.
- Set vs clear collision: W1C of bit 2 on the same cycle its press is accepted → EDGECAP[2] remains 1.
- Reset mid-debounce:
  - Drop bit 3, then assert `reset` after 2 mismatch cycles.
  - After release, DATA reads 0xF; 6 cycles later it reads 0x7 and EDGECAP=0x8.
